outmem_reader: RTL and testbench
================================

OUTMEM_READER -- requirements
Module: outmem_reader

Interface
REQ-001 The block SHALL have parameter AW, default 4, output-memory address width (16 entries).
REQ-002 The block SHALL have parameter EW, default 16, element width; 4*EW SHALL equal 64.
REQ-003 The block SHALL have port CLK  input  1  the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port START  input  1  one-cycle request to drain the output memory.
REQ-006 The block SHALL have port MNT  input  12  matrix dimensions: M=[11:8], N=[7:4], T=[3:0]; sampled when START is accepted.
REQ-007 The block SHALL have port EN_O  output  1  output-memory read enable (chip select, active-high).
REQ-008 The block SHALL have port ADDR_O  output  AW  output-memory read address.
REQ-009 The block SHALL have port RDATA_O  input  64  read data, valid the cycle after EN_O is high.
REQ-010 The block SHALL have port OUT_VALID  output  1  stream element valid.
REQ-011 The block SHALL have port OUT_READY  input  1  stream consumer ready.
REQ-012 The block SHALL have port OUT_DATA  output  EW  element value.
REQ-013 The block SHALL have port OUT_ROW  output  3  zero-based row index r.
REQ-014 The block SHALL have port OUT_COL  output  3  zero-based column index c.
REQ-015 The block SHALL have port OUT_LAST  output  1  marks the final element of a drain.
REQ-016 The block SHALL have port BUSY  output  1  high from START acceptance until DONE.
REQ-017 The block SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-018 The block SHALL have port ERR  output  1  one-cycle pulse, coincident with DONE, on invalid MNT.

Function
REQ-019 Memory layout: element (r,c) SHALL be read from address 2r+c[2], lane c[1:0], at bits [63-16*lane -: 16], so lane 0 is the MSBs.
REQ-020 States SHALL be IDLE, READ, WAIT and EMIT.
REQ-021 IDLE: START=1 SHALL latch MNT, set BUSY, and go to READ.
REQ-022 In any non-IDLE state, START SHALL be ignored.
REQ-023 MNT is invalid when M=0, M>8, T=0 or T>8; invalid MNT at START SHALL give DONE=ERR=1 next cycle, no reads, no stream beats, and a return to IDLE.
REQ-024 READ: EN_O=1 and ADDR_O=current address for exactly one cycle, then WAIT.
REQ-025 WAIT: RDATA_O SHALL be captured into a 64-bit word register, then EMIT.
REQ-026 Latency SHALL be: START accepted at cycle 0, EN_O at cycle 1, capture at cycle 2, first OUT_VALID at cycle 3.
REQ-027 EMIT: OUT_VALID=1 with OUT_DATA, OUT_ROW and OUT_COL of the current element, all stable while OUT_READY=0.
REQ-028 EMIT: a beat transfers when OUT_VALID and OUT_READY are both 1; c SHALL then advance.
REQ-029 Elements SHALL be streamed row-major; only r<T and c<M are emitted, so total beats = T*M.
REQ-030 Word 2r+1 SHALL be read only when M>4.
REQ-031 After the beat for c=3 with M>4, the block SHALL go to READ for address 2r+1.
REQ-032 After the beat for c=M-1 with r<T-1, the block SHALL go to READ for address 2(r+1), with c=0.
REQ-033 OUT_LAST SHALL be 1 only with r=T-1 and c=M-1.
REQ-034 The transfer of the OUT_LAST beat SHALL pulse DONE the next cycle, clear BUSY in that same cycle, and return to IDLE.
REQ-035 EN_O SHALL be 0 outside READ; ADDR_O SHALL hold its last value when EN_O=0.
REQ-036 N SHALL be latched but SHALL NOT affect behaviour.
REQ-037 There SHALL be no write port; the block never writes the memory.

Reset
REQ-038 RST=1 at any clock edge, including mid-drain, SHALL force IDLE on that edge.
REQ-039 Reset values SHALL be: EN_O=0, ADDR_O=0, OUT_VALID=0, OUT_DATA=0, OUT_ROW=0, OUT_COL=0, OUT_LAST=0, BUSY=0, DONE=0, ERR=0, word register 0.
REQ-040 After reset is released, the first START SHALL behave as in REQ-026; a drain interrupted by reset is not resumed.

Verification
REQ-041 MNT=12'h568 with OUT_READY=1 -> 16 reads at addresses 0..15, 40 beats (8 rows x 5 cols), OUT_LAST on (7,4), DONE once, ERR=0.
REQ-042 MNT=12'h444, memory word at address 2r = {r,0},{r,1},{r,2},{r,3} -> reads at 0,2,4,6 only, 16 beats with matching data, first OUT_VALID at cycle 3.
REQ-043 MNT=12'h888 with OUT_READY toggling 1/0 every cycle -> outputs stable while stalled, 64 beats in order, no duplicated or dropped elements.
REQ-044 MNT=12'h058 (M=0) and MNT=12'h509 (T=9) -> DONE=ERR=1 one cycle after START, EN_O never high, OUT_VALID never high.
REQ-045 RST=1 after beat 10 of MNT=12'h568 -> all outputs at reset values next cycle; a new START completes a full 40-beat drain.
REQ-046 START re-pulsed mid-drain with a different MNT -> ignored; the original dimensions complete unchanged.

Source files
------------

// File: rtl/outmem_reader.sv
// Drains a row-major result matrix out of a 64-bit-wide output memory and
// streams it one element per beat over a valid/ready interface.
module outmem_reader #(
    parameter int AW = 4,
    parameter int EW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [11:0]   MNT,
    output logic          EN_O,
    output logic [AW-1:0] ADDR_O,
    input  logic [63:0]   RDATA_O,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [EW-1:0] OUT_DATA,
    output logic [2:0]    OUT_ROW,
    output logic [2:0]    OUT_COL,
    output logic          OUT_LAST,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        EMIT = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [3:0]      m_r;
    logic [3:0]      n_r;
    logic [3:0]      t_r;
    logic [2:0]      row_r;
    logic [2:0]      col_r;
    logic [AW-1:0]   addr_r;
    logic [63:0]     word_r;
    logic            done_r;
    logic            err_r;
    logic            mnt_ok_s;
    logic            beat_s;
    logic            col_end_s;
    logic            row_end_s;
    logic            half_s;
    logic            unused_s;

    function automatic logic mnt_valid(input logic [11:0] mnt);
        return (mnt[11:8] != 4'd0) && (mnt[11:8] <= 4'd8) &&
               (mnt[3:0]  != 4'd0) && (mnt[3:0]  <= 4'd8);
    endfunction

    // Lane 0 sits in the most significant bits of the word.
    function automatic logic [EW-1:0] lane_sel(input logic [63:0] word, input logic [1:0] lane);
        case (lane)
            2'd0:    lane_sel = word[63 -: EW];
            2'd1:    lane_sel = word[63 - EW -: EW];
            2'd2:    lane_sel = word[63 - 2*EW -: EW];
            default: lane_sel = word[63 - 3*EW -: EW];
        endcase
    endfunction

    function automatic logic [AW-1:0] addr_of(input logic [2:0] row, input logic half);
        return AW'({row, half});
    endfunction

    assign mnt_ok_s  = mnt_valid(MNT);
    assign beat_s    = (state_r == EMIT) && OUT_READY;
    assign col_end_s = (col_r == 3'(m_r - 4'd1));
    assign row_end_s = (row_r == 3'(t_r - 4'd1));
    assign half_s    = (col_r == 3'd3) && (m_r > 4'd4);
    // N is carried with the request but plays no part in the drain.
    assign unused_s  = ^n_r;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (START && mnt_ok_s) state_s = READ;
                else                   state_s = IDLE;
            end
            READ: state_s = WAIT;
            WAIT: state_s = EMIT;
            EMIT: begin
                if (beat_s) begin
                    if (col_end_s)   state_s = row_end_s ? IDLE : READ;
                    else if (half_s) state_s = READ;
                    else             state_s = EMIT;
                end else begin
                    state_s = EMIT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Dimension latch, element indices, read address, captured word and completion pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            m_r    <= 4'd0;
            n_r    <= 4'd0;
            t_r    <= 4'd0;
            row_r  <= 3'd0;
            col_r  <= 3'd0;
            addr_r <= '0;
            word_r <= 64'd0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (START) begin
                        m_r <= MNT[11:8];
                        n_r <= MNT[7:4];
                        t_r <= MNT[3:0];
                        if (mnt_ok_s) begin
                            row_r  <= 3'd0;
                            col_r  <= 3'd0;
                            addr_r <= addr_of(3'd0, 1'b0);
                        end else begin
                            done_r <= 1'b1;
                            err_r  <= 1'b1;
                        end
                    end
                end
                WAIT: word_r <= RDATA_O;
                EMIT: begin
                    if (beat_s) begin
                        if (col_end_s) begin
                            if (row_end_s) begin
                                done_r <= 1'b1;
                            end else begin
                                row_r  <= row_r + 3'd1;
                                col_r  <= 3'd0;
                                addr_r <= addr_of(row_r + 3'd1, 1'b0);
                            end
                        end else begin
                            col_r <= col_r + 3'd1;
                            if (half_s) addr_r <= addr_of(row_r, 1'b1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode from registered state.
    always_comb begin
        EN_O      = (state_r == READ);
        ADDR_O    = addr_r;
        OUT_VALID = (state_r == EMIT);
        OUT_DATA  = '0;
        OUT_ROW   = 3'd0;
        OUT_COL   = 3'd0;
        OUT_LAST  = 1'b0;
        if (state_r == EMIT) begin
            OUT_DATA = lane_sel(word_r, col_r[1:0]);
            OUT_ROW  = row_r;
            OUT_COL  = col_r;
            OUT_LAST = col_end_s && row_end_s;
        end else begin
            OUT_DATA = '0;
        end
        BUSY = (state_r != IDLE);
        DONE = done_r;
        ERR  = err_r;
    end

endmodule

// File: tb/tb_outmem_reader.sv
// Directed bench for outmem_reader: behavioural output memory plus per-beat
// checks of data, indices, read addresses, latency and completion pulses.
module tb_outmem_reader;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [11:0] MNT;
    logic        EN_O;
    logic [3:0]  ADDR_O;
    logic [63:0] RDATA_O;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [15:0] OUT_DATA;
    logic [2:0]  OUT_ROW;
    logic [2:0]  OUT_COL;
    logic        OUT_LAST;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    logic [63:0] mem [16];
    int checks = 0;
    int errors = 0;

    outmem_reader #(.AW(4), .EW(16)) dut (
        .CLK(CLK), .RST(RST), .START(START), .MNT(MNT),
        .EN_O(EN_O), .ADDR_O(ADDR_O), .RDATA_O(RDATA_O),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .OUT_ROW(OUT_ROW), .OUT_COL(OUT_COL), .OUT_LAST(OUT_LAST),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Synchronous-read output memory.
    always @(posedge CLK) begin
        if (EN_O) RDATA_O <= mem[ADDR_O];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_en"},    {63'd0, EN_O},      64'd0);
        chk({tag, "_addr"},  {60'd0, ADDR_O},    64'd0);
        chk({tag, "_valid"}, {63'd0, OUT_VALID}, 64'd0);
        chk({tag, "_data"},  {48'd0, OUT_DATA},  64'd0);
        chk({tag, "_row"},   {61'd0, OUT_ROW},   64'd0);
        chk({tag, "_col"},   {61'd0, OUT_COL},   64'd0);
        chk({tag, "_last"},  {63'd0, OUT_LAST},  64'd0);
        chk({tag, "_busy"},  {63'd0, BUSY},      64'd0);
        chk({tag, "_done"},  {63'd0, DONE},      64'd0);
        chk({tag, "_err"},   {63'd0, ERR},       64'd0);
    endtask

    // One drain request; abort_at >= 0 stops once that many beats are committed.
    task automatic drain(input string tag, input logic [11:0] mnt, input int toggle,
                         input int abort_at, input logic [11:0] restart_mnt, input int restart_cyc);
        int m, t, bad, exp_beats, beats, cyc, first_valid, done_cnt, valid_seen, r, c;
        int exp_addr[$];
        int got_addr[$];
        logic finished, stalled, err_seen;
        logic [15:0] prev_data;
        logic [2:0]  prev_row, prev_col;
        logic [7:0]  rb, cb;
        m = int'(mnt[11:8]);
        t = int'(mnt[3:0]);
        bad = (m == 0 || m > 8 || t == 0 || t > 8) ? 1 : 0;
        exp_beats = bad ? 0 : m * t;
        if (bad == 0) begin
            for (int i = 0; i < t; i++) begin
                exp_addr.push_back(2 * i);
                if (m > 4) exp_addr.push_back(2 * i + 1);
            end
        end
        beats = 0; first_valid = -1; done_cnt = 0; valid_seen = 0; r = 0; c = 0;
        finished = 1'b0; stalled = 1'b0; err_seen = 1'b0;
        prev_data = 16'd0; prev_row = 3'd0; prev_col = 3'd0;
        @(negedge CLK);
        START = 1'b1; MNT = mnt; OUT_READY = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        cyc = 1;
        while (!finished && cyc < 400) begin
            START = (cyc == restart_cyc);
            MNT = (cyc == restart_cyc) ? restart_mnt : mnt;
            OUT_READY = (toggle != 0) ? cyc[0] : 1'b1;
            if (EN_O) got_addr.push_back(int'(ADDR_O));
            if (OUT_VALID) begin
                valid_seen++;
                if (first_valid < 0) first_valid = cyc;
                if (stalled) begin
                    chk({tag, "_stall_data"}, {48'd0, OUT_DATA}, {48'd0, prev_data});
                    chk({tag, "_stall_row"},  {61'd0, OUT_ROW},  {61'd0, prev_row});
                    chk({tag, "_stall_col"},  {61'd0, OUT_COL},  {61'd0, prev_col});
                end
                if (OUT_READY) begin
                    rb = 8'(r);
                    cb = 8'(c);
                    chk({tag, "_data"}, {48'd0, OUT_DATA}, {48'd0, rb, cb});
                    chk({tag, "_row"},  {61'd0, OUT_ROW},  64'(r));
                    chk({tag, "_col"},  {61'd0, OUT_COL},  64'(c));
                    chk({tag, "_last"}, {63'd0, OUT_LAST}, (r == t - 1 && c == m - 1) ? 64'd1 : 64'd0);
                    c++;
                    if (c == m) begin
                        c = 0;
                        r++;
                    end
                    beats++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    prev_data = OUT_DATA;
                    prev_row = OUT_ROW;
                    prev_col = OUT_COL;
                end
            end
            if (DONE) begin
                done_cnt++;
                err_seen = ERR;
                chk({tag, "_busy_at_done"}, {63'd0, BUSY}, 64'd0);
                if (bad != 0) chk({tag, "_done_cycle"}, 64'(cyc), 64'd1);
                finished = 1'b1;
            end
            if (abort_at >= 0 && beats == abort_at) finished = 1'b1;
            if (!finished) begin
                @(negedge CLK);
                cyc++;
            end
        end
        START = 1'b0;
        MNT = mnt;
        if (!finished) chk({tag, "_timeout"}, 64'd0, 64'd1);
        if (abort_at < 0) begin
            chk({tag, "_beats"}, 64'(beats), 64'(exp_beats));
            chk({tag, "_nreads"}, 64'(got_addr.size()), 64'(exp_addr.size()));
            for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
                chk({tag, "_raddr"}, 64'(got_addr[i]), 64'(exp_addr[i]));
            chk({tag, "_first_valid"}, 64'(first_valid), (bad != 0) ? -64'sd1 : 64'd3);
            chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
            chk({tag, "_err"}, {63'd0, err_seen}, 64'(bad));
            @(negedge CLK);
            chk({tag, "_done_pulse"}, {63'd0, DONE}, 64'd0);
            chk({tag, "_idle_busy"}, {63'd0, BUSY}, 64'd0);
        end
    endtask

    initial begin
        logic [7:0] rb, cb;
        for (int a = 0; a < 16; a++) begin
            mem[a] = 64'd0;
            for (int lane = 0; lane < 4; lane++) begin
                rb = 8'(a / 2);
                cb = 8'((a % 2) * 4 + lane);
                mem[a][63 - 16 * lane -: 16] = {rb, cb};
            end
        end
        RST = 1'b1; START = 1'b0; MNT = 12'd0; OUT_READY = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_outputs("por");
        RST = 1'b0;

        drain("m5t8", 12'h568, 0, -1, 12'h000, -1);
        drain("m4t4", 12'h444, 0, -1, 12'h000, -1);
        drain("m8t8_stall", 12'h888, 1, -1, 12'h000, -1);
        drain("bad_m0", 12'h058, 0, -1, 12'h000, -1);
        drain("bad_t9", 12'h509, 0, -1, 12'h000, -1);

        drain("abort", 12'h568, 0, 10, 12'h000, -1);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check_reset_outputs("midrst");
        RST = 1'b0;
        drain("after_rst", 12'h568, 0, -1, 12'h000, -1);

        drain("restart_ign", 12'h444, 0, -1, 12'h888, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
